instr_fetch_unit: RTL and testbench



---
 rtl/instr_fetch_unit_pkg.sv | 18 +
 rtl/fetch_timeout_counter.sv | 27 ++
 rtl/instr_fetch_unit.sv | 114 +++++++++++
 tb/tb_instr_fetch_unit.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit and its benches.
package instr_fetch_unit_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    ERR  = 3'd4
  } fetch_state_e;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_timeout_counter.sv
// Counts WAIT cycles; expired flags the enabled cycle in which the count reaches TIMEOUT.
module fetch_timeout_counter #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = en && (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetches the word at pc over req/gnt/rvalid, holds it for decode, pulses inc on acceptance.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_en,
  input  logic            flush,
  input  logic [XLEN-1:0] pc,
  output logic            inc,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
  output logic            err,
  output logic [1:0]      err_code
);

  fetch_state_e state;
  logic         discard;
  logic         expired;
  logic         misaligned;

  assign misaligned  = |pc[1:0];
  assign mem_req     = (state == REQ);
  assign mem_addr    = mem_req ? pc : '0;
  assign instr_valid = (state == HOLD);
  assign err         = (state == ERR);
  assign inc         = (state == HOLD) && instr_ready && !flush;

  fetch_timeout_counter #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     ((state != WAIT) || mem_rvalid),
    .en      (state == WAIT),
    .expired (expired)
  );

  // A flush in REQ takes priority over the alignment check: pc is being reloaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      instr    <= '0;
      instr_pc <= '0;
      err_code <= ERR_NONE;
      discard  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fetch_en) state <= REQ;
        end
        REQ: begin
          if (flush) begin
            state <= REQ;
          end else if (misaligned) begin
            state    <= ERR;
            err_code <= ERR_MISALIGN;
            instr    <= '0;
            instr_pc <= '0;
          end else if (mem_gnt) begin
            state    <= WAIT;
            instr_pc <= pc;
            discard  <= 1'b0;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            discard <= 1'b0;
            if (discard || flush) begin
              state <= REQ;
            end else begin
              instr <= mem_rdata;
              state <= HOLD;
            end
          end else if (expired) begin
            state    <= ERR;
            err_code <= ERR_TIMEOUT;
            instr    <= '0;
            instr_pc <= '0;
            discard  <= 1'b0;
          end else if (flush) begin
            discard <= 1'b1;
          end
        end
        HOLD: begin
          if (flush) begin
            state <= REQ;
          end else if (instr_ready) begin
            state <= fetch_en ? REQ : IDLE;
          end
        end
        ERR: begin
          state <= ERR;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: vector table for the main flow, hand sequences for corners.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        fetch_en;
  logic        flush;
  logic [31:0] pc;
  logic        inc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        err;
  logic [1:0]  err_code;

  int checks = 0;
  int errors = 0;

  instr_fetch_unit #(.XLEN(32), .TIMEOUT(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_en    (fetch_en),
    .flush       (flush),
    .pc          (pc),
    .inc         (inc),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .err         (err),
    .err_code    (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  typedef struct {
    logic        fe;
    logic        fl;
    logic [31:0] pc;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        rdy;
    logic        e_inc;
    logic        e_req;
    logic        e_vld;
    logic [31:0] e_instr;
    logic [31:0] e_ipc;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic fe, input logic fl, input logic [31:0] p, input logic g,
                       input logic rv, input logic [31:0] rd, input logic rdy);
    fetch_en = fe; flush = fl; pc = p; mem_gnt = g;
    mem_rvalid = rv; mem_rdata = rd; instr_ready = rdy;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  // Inputs change at the falling edge; checks run 1 time unit later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".inc"},         32'(inc),         32'h0);
    chk({tag, ".mem_req"},     32'(mem_req),     32'h0);
    chk({tag, ".mem_addr"},    mem_addr,         32'h0);
    chk({tag, ".instr_valid"}, 32'(instr_valid), 32'h0);
    chk({tag, ".instr"},       instr,            32'h0);
    chk({tag, ".instr_pc"},    instr_pc,         32'h0);
    chk({tag, ".err"},         32'(err),         32'h0);
    chk({tag, ".err_code"},    32'(err_code),    32'h0);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();

    //            fe    fl    pc            gnt   rv    rdata         rdy   inc   req   vld   instr         ipc
    vecs[0]  = '{1'b1, 1'b0, 32'h1000, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'h1000, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0};
    vecs[2]  = '{1'b1, 1'b0, 32'h1000, 1'b0, 1'b1, 32'h00500093, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h1000};
    vecs[3]  = '{1'b1, 1'b0, 32'h1000, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 32'h00500093, 32'h1000};
    vecs[4]  = '{1'b1, 1'b0, 32'h1004, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00500093, 32'h1000};
    vecs[5]  = '{1'b1, 1'b0, 32'h1004, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h00500093, 32'h1000};
    vecs[6]  = '{1'b0, 1'b0, 32'h1004, 1'b0, 1'b1, 32'h00A00113, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00500093, 32'h1004};
    vecs[7]  = '{1'b0, 1'b0, 32'h1004, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h00A00113, 32'h1004};
    vecs[8]  = '{1'b0, 1'b0, 32'h1004, 1'b0, 1'b1, 32'hBAD0BAD0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00A00113, 32'h1004};
    vecs[9]  = '{1'b0, 1'b0, 32'h1004, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h00A00113, 32'h1004};
    vecs[10] = '{1'b0, 1'b0, 32'h1004, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h00A00113, 32'h1004};
    vecs[11] = '{1'b0, 1'b0, 32'h1004, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h00A00113, 32'h1004};
    vecs[12] = '{1'b0, 1'b0, 32'h1004, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 32'h00A00113, 32'h1004};
    vecs[13] = '{1'b0, 1'b0, 32'h1004, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h00A00113, 32'h1004};

    // Reset state
    @(negedge clk);
    #1;
    chk_all_zero("reset");
    do_reset();

    // Main flow: fetch, accept, back-to-back request, then stall in HOLD for 5 cycles
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].fe, vecs[i].fl, vecs[i].pc, vecs[i].gnt, vecs[i].rv, vecs[i].rdata, vecs[i].rdy);
      #1;
      chk($sformatf("vec%0d.inc", i),         32'(inc),         32'(vecs[i].e_inc));
      chk($sformatf("vec%0d.mem_req", i),     32'(mem_req),     32'(vecs[i].e_req));
      chk($sformatf("vec%0d.mem_addr", i),    mem_addr,         vecs[i].e_req ? vecs[i].pc : 32'h0);
      chk($sformatf("vec%0d.instr_valid", i), 32'(instr_valid), 32'(vecs[i].e_vld));
      chk($sformatf("vec%0d.instr", i),       instr,            vecs[i].e_instr);
      chk($sformatf("vec%0d.instr_pc", i),    instr_pc,         vecs[i].e_ipc);
      chk($sformatf("vec%0d.err", i),         32'(err),         32'h0);
      next_cycle();
    end

    // Misaligned pc goes to ERR and stays there until reset
    do_reset();
    drive(1'b1, 1'b0, 32'h1002, 1'b1, 1'b0, 32'h0, 1'b0);
    next_cycle();
    #1;
    chk("mis.req_in_req", 32'(mem_req), 32'h1);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mis.err",         32'(err),         32'h1);
      chk("mis.err_code",    32'(err_code),    32'h1);
      chk("mis.mem_req",     32'(mem_req),     32'h0);
      chk("mis.instr_valid", 32'(instr_valid), 32'h0);
      chk("mis.inc",         32'(inc),         32'h0);
      next_cycle();
    end
    do_reset();
    #1;
    chk_all_zero("mis.after_rst");
    next_cycle();
    #1;
    chk("mis.idle_req", 32'(mem_req), 32'h0);

    // Flush during WAIT discards the returning word and re-requests with the new pc
    do_reset();
    drive(1'b1, 1'b0, 32'h2000, 1'b0, 1'b0, 32'h0, 1'b1);
    next_cycle();
    mem_gnt = 1'b1;
    #1;
    chk("fl.req_addr", mem_addr, 32'h2000);
    next_cycle();
    drive(1'b1, 1'b1, 32'h3000, 1'b0, 1'b0, 32'h0, 1'b1);
    #1;
    chk("fl.ipc", instr_pc, 32'h2000);
    next_cycle();
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mem_rvalid = (i == 1);
      mem_rdata  = 32'hDEADBEEF;
      #1;
      chk("fl.vld_wait", 32'(instr_valid), 32'h0);
      chk("fl.inc_wait", 32'(inc),         32'h0);
      next_cycle();
    end
    mem_rvalid = 1'b0;
    #1;
    chk("fl.req_again", 32'(mem_req),     32'h1);
    chk("fl.addr_new",  mem_addr,         32'h3000);
    chk("fl.vld",       32'(instr_valid), 32'h0);
    chk("fl.inc",       32'(inc),         32'h0);
    chk("fl.instr",     instr,            32'h0);

    // Flush wins over instr_ready in HOLD
    do_reset();
    drive(1'b1, 1'b0, 32'h6000, 1'b1, 1'b0, 32'h0, 1'b0);
    next_cycle();
    next_cycle();
    drive(1'b1, 1'b0, 32'h6000, 1'b0, 1'b1, 32'h00000013, 1'b0);
    next_cycle();
    drive(1'b1, 1'b1, 32'h6004, 1'b0, 1'b0, 32'h0, 1'b1);
    #1;
    chk("hfl.vld",   32'(instr_valid), 32'h1);
    chk("hfl.instr", instr,            32'h00000013);
    chk("hfl.inc",   32'(inc),         32'h0);
    next_cycle();
    drive(1'b1, 1'b0, 32'h6004, 1'b0, 1'b0, 32'h0, 1'b1);
    #1;
    chk("hfl.vld_after", 32'(instr_valid), 32'h0);
    chk("hfl.req_after", 32'(mem_req),     32'h1);
    chk("hfl.inc_after", 32'(inc),         32'h0);

    // Timeout: 16 WAIT cycles without rvalid
    do_reset();
    drive(1'b1, 1'b0, 32'h4000, 1'b1, 1'b0, 32'h0, 1'b0);
    next_cycle();
    next_cycle();
    idle_inputs();
    for (int i = 1; i <= 16; i++) begin
      #1;
      chk($sformatf("to.err_wait%0d", i), 32'(err), 32'h0);
      next_cycle();
    end
    #1;
    chk("to.err",      32'(err),      32'h1);
    chk("to.err_code", 32'(err_code), 32'h2);
    chk("to.mem_req",  32'(mem_req),  32'h0);
    chk("to.instr_pc", instr_pc,      32'h0);

    // Asynchronous reset mid-WAIT; a late rvalid must be ignored
    do_reset();
    drive(1'b1, 1'b0, 32'h5000, 1'b1, 1'b0, 32'h0, 1'b0);
    next_cycle();
    next_cycle();
    idle_inputs();
    next_cycle();
    #1;
    chk("ar.ipc_before", instr_pc, 32'h5000);
    #1;
    rst = 1'b1;
    #1;
    chk("ar.ipc_async", instr_pc, 32'h0);
    chk_all_zero("ar.async");
    next_cycle();
    rst = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ar.vld",   32'(instr_valid), 32'h0);
      chk("ar.instr", instr,            32'h0);
      chk("ar.inc",   32'(inc),         32'h0);
      chk("ar.req",   32'(mem_req),     32'h0);
      next_cycle();
      mem_rvalid = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
